// File: rtl/vga_sync_rx.sv
// vga_sync_rx: recovers pixel position, display window and lock status from
// an incoming hsync/vsync pair clocked by a pixel-enable tick. The line and
// frame periods are measured at every sync rise; lock is declared after
// LOCK_CNT consecutive periods of the nominal length, and any loss of a held
// lock (or a run-away period counter) raises a sticky timing error.
module vga_sync_rx #(
  parameter int HD           = 640,
  parameter int H_SYNC_START = 656,
  parameter int H_TOTAL      = 800,
  parameter int VD           = 480,
  parameter int V_SYNC_START = 513,
  parameter int V_TOTAL      = 525,
  parameter int LOCK_CNT     = 2
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_p_tick,
  input  logic       i_hsync_in,
  input  logic       i_vsync_in,
  input  logic       i_err_clr,
  output logic [9:0] o_pixel_x,
  output logic [9:0] o_pixel_y,
  output logic       o_video_on,
  output logic       o_locked,
  output logic       o_frame_start,
  output logic       o_timing_err
);

  // Position constants, sized to the 10-bit counters.
  localparam logic [9:0]  C_X_LOAD   = 10'(H_SYNC_START);
  localparam logic [9:0]  C_X_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  C_Y_LOAD   = 10'(V_SYNC_START);
  localparam logic [9:0]  C_Y_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  C_HD       = 10'(HD);
  localparam logic [9:0]  C_VD       = 10'(VD);
  // A good line leaves h_per at H_TOTAL-1 just before it is cleared.
  localparam logic [9:0]  C_H_GOOD   = 10'(H_TOTAL - 1);
  // A good frame counts V_TOTAL line wraps, including one on the rise tick.
  localparam logic [10:0] C_V_GOOD   = 11'(V_TOTAL);
  localparam logic [9:0]  C_PER_MAX  = 10'd1023;
  localparam logic [9:0]  C_PER_NEAR = 10'd1022;
  localparam logic [2:0]  C_LOCK     = 3'(LOCK_CNT);

  // Registered state.
  logic       r_hs_d;
  logic       r_vs_d;
  logic [9:0] r_x;
  logic [9:0] r_y;
  logic [9:0] r_h_per;
  logic [9:0] r_v_per;
  logic       r_h_seen;
  logic       r_v_seen;
  logic [2:0] r_h_lk;
  logic [2:0] r_v_lk;
  logic       r_err;
  logic       r_fs;

  // Combinational next-state and decode.
  logic       w_h_rise;
  logic       w_v_rise;
  logic       w_wrap;
  logic [9:0] w_x_nxt;
  logic [9:0] w_y_nxt;
  logic [9:0] w_h_per_nxt;
  logic [9:0] w_v_per_nxt;
  logic       w_h_match;
  logic       w_v_match;
  logic       w_h_sat;
  logic       w_v_sat;
  logic       w_h_locked;
  logic       w_v_locked;
  logic [2:0] w_h_lk_nxt;
  logic [2:0] w_v_lk_nxt;
  logic       w_err_set;
  logic       w_err_nxt;
  logic       w_fs_nxt;

  // Sync rising edges, seen on the tick itself against the last sampled level.
  always_comb begin
    w_h_rise = i_p_tick & i_hsync_in & ~r_hs_d;
    w_v_rise = i_p_tick & i_vsync_in & ~r_vs_d;
  end

  // Column counter: hsync rise realigns, otherwise free-run modulo H_TOTAL.
  always_comb begin
    w_x_nxt = r_x;
    w_wrap  = 1'b0;
    if (i_p_tick) begin
      if (w_h_rise) begin
        w_x_nxt = C_X_LOAD;
      end else if (r_x == C_X_LAST) begin
        w_x_nxt = 10'd0;
        w_wrap  = 1'b1;
      end else begin
        w_x_nxt = r_x + 10'd1;
      end
    end else begin
      w_x_nxt = r_x;
    end
  end

  // Row counter: vsync rise realigns and beats a same-tick line wrap.
  always_comb begin
    w_y_nxt = r_y;
    if (w_v_rise) begin
      w_y_nxt = C_Y_LOAD;
    end else if (w_wrap) begin
      if (r_y == C_Y_LAST) begin
        w_y_nxt = 10'd0;
      end else begin
        w_y_nxt = r_y + 10'd1;
      end
    end else begin
      w_y_nxt = r_y;
    end
  end

  // Line period in ticks; compared before it is cleared by the hsync rise.
  always_comb begin
    w_h_per_nxt = r_h_per;
    w_h_match   = w_h_rise & r_h_seen & (r_h_per == C_H_GOOD);
    w_h_sat     = i_p_tick & ~w_h_rise & (r_h_per >= C_PER_NEAR);
    if (i_p_tick) begin
      if (w_h_rise) begin
        w_h_per_nxt = 10'd0;
      end else if (r_h_per != C_PER_MAX) begin
        w_h_per_nxt = r_h_per + 10'd1;
      end else begin
        w_h_per_nxt = r_h_per;
      end
    end else begin
      w_h_per_nxt = r_h_per;
    end
  end

  // Frame period in lines; a wrap on the rise tick still counts toward it.
  always_comb begin
    w_v_per_nxt = r_v_per;
    w_v_match   = w_v_rise & r_v_seen &
                  (({1'b0, r_v_per} + {10'd0, w_wrap}) == C_V_GOOD);
    w_v_sat     = w_wrap & ~w_v_rise & (r_v_per >= C_PER_NEAR);
    if (w_v_rise) begin
      w_v_per_nxt = 10'd0;
    end else if (w_wrap) begin
      if (r_v_per != C_PER_MAX) begin
        w_v_per_nxt = r_v_per + 10'd1;
      end else begin
        w_v_per_nxt = r_v_per;
      end
    end else begin
      w_v_per_nxt = r_v_per;
    end
  end

  // Lock counters: count consecutive good periods, drop to zero on a bad one.
  always_comb begin
    w_h_locked = (r_h_lk == C_LOCK);
    w_v_locked = (r_v_lk == C_LOCK);
    w_h_lk_nxt = r_h_lk;
    w_v_lk_nxt = r_v_lk;
    if (w_h_rise) begin
      if (w_h_match) begin
        w_h_lk_nxt = w_h_locked ? r_h_lk : (r_h_lk + 3'd1);
      end else begin
        w_h_lk_nxt = 3'd0;
      end
    end else begin
      w_h_lk_nxt = r_h_lk;
    end
    if (w_v_rise) begin
      if (w_v_match) begin
        w_v_lk_nxt = w_v_locked ? r_v_lk : (r_v_lk + 3'd1);
      end else begin
        w_v_lk_nxt = 3'd0;
      end
    end else begin
      w_v_lk_nxt = r_v_lk;
    end
  end

  // Sticky timing error: a new violation outranks a clear on the same tick.
  always_comb begin
    w_err_set = (w_h_rise & ~w_h_match & w_h_locked) |
                (w_v_rise & ~w_v_match & w_v_locked) |
                w_h_sat | w_v_sat;
    if (w_err_set) begin
      w_err_nxt = 1'b1;
    end else if (i_p_tick & i_err_clr) begin
      w_err_nxt = 1'b0;
    end else begin
      w_err_nxt = r_err;
    end
  end

  // Frame start: the position is about to become (0,0) from somewhere else.
  always_comb begin
    if (i_p_tick) begin
      w_fs_nxt = (w_x_nxt == 10'd0) & (w_y_nxt == 10'd0) &
                 ((r_x != 10'd0) | (r_y != 10'd0));
    end else begin
      w_fs_nxt = 1'b0;
    end
  end

  // Sync sampling and position registers, advanced only on ticks.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_hs_d <= 1'b0;
      r_vs_d <= 1'b0;
      r_x    <= 10'd0;
      r_y    <= 10'd0;
    end else if (i_p_tick) begin
      r_hs_d <= i_hsync_in;
      r_vs_d <= i_vsync_in;
      r_x    <= w_x_nxt;
      r_y    <= w_y_nxt;
    end else begin
      r_hs_d <= r_hs_d;
      r_vs_d <= r_vs_d;
      r_x    <= r_x;
      r_y    <= r_y;
    end
  end

  // Period measurement, first-edge flags and lock counters.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_h_per  <= 10'd0;
      r_v_per  <= 10'd0;
      r_h_seen <= 1'b0;
      r_v_seen <= 1'b0;
      r_h_lk   <= 3'd0;
      r_v_lk   <= 3'd0;
    end else begin
      r_h_per  <= w_h_per_nxt;
      r_v_per  <= w_v_per_nxt;
      r_h_seen <= r_h_seen | w_h_rise;
      r_v_seen <= r_v_seen | w_v_rise;
      r_h_lk   <= w_h_lk_nxt;
      r_v_lk   <= w_v_lk_nxt;
    end
  end

  // Error flag and frame-start pulse.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_err <= 1'b0;
      r_fs  <= 1'b0;
    end else begin
      r_err <= w_err_nxt;
      r_fs  <= w_fs_nxt;
    end
  end

  // Outputs: lock and display window decode straight from registers.
  always_comb begin
    o_pixel_x     = r_x;
    o_pixel_y     = r_y;
    o_locked      = w_h_locked & w_v_locked;
    o_video_on    = w_h_locked & w_v_locked & (r_x < C_HD) & (r_y < C_VD);
    o_frame_start = r_fs;
    o_timing_err  = r_err;
  end

endmodule

// File: tb/tb_vga_sync_rx.sv
// Self-checking bench for vga_sync_rx using a scaled-down raster so that
// several frames fit in a short run. A source raster generator drives the
// syncs; a timestamp-based reference model predicts the receiver outputs.
module tb_vga_sync_rx;

  localparam int HD  = 16;
  localparam int HSS = 18;
  localparam int HT  = 24;
  localparam int HW  = 3;
  localparam int VD  = 8;
  localparam int VSS = 10;
  localparam int VT  = 12;
  localparam int VW  = 2;
  localparam int LK  = 2;

  logic       clk;
  logic       reset;
  logic       p_tick;
  logic       hs_in;
  logic       vs_in;
  logic       err_clr;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       video_on;
  logic       locked;
  logic       frame_start;
  logic       timing_err;

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_t, m_base, m_hhave, m_x, m_y, m_vhave, m_vcnt, m_hlk, m_vlk;
  bit m_err, m_fs, m_hs, m_vs, m_hr_last, m_vr_last;
  // source raster: next position to present, and the last one presented
  int sx, sy, ps_x, ps_y;

  vga_sync_rx #(
    .HD(HD), .H_SYNC_START(HSS), .H_TOTAL(HT),
    .VD(VD), .V_SYNC_START(VSS), .V_TOTAL(VT), .LOCK_CNT(LK)
  ) dut (
    .i_clk(clk), .i_reset(reset), .i_p_tick(p_tick),
    .i_hsync_in(hs_in), .i_vsync_in(vs_in), .i_err_clr(err_clr),
    .o_pixel_x(pixel_x), .o_pixel_y(pixel_y), .o_video_on(video_on),
    .o_locked(locked), .o_frame_start(frame_start), .o_timing_err(timing_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit exp_locked();
    return (m_hlk == LK) && (m_vlk == LK);
  endfunction

  function automatic bit exp_video();
    return exp_locked() && (m_x < HD) && (m_y < VD);
  endfunction

  task automatic model_reset();
    m_t = 0; m_base = 0; m_hhave = 0; m_x = 0; m_y = 0;
    m_vhave = 0; m_vcnt = 0; m_hlk = 0; m_vlk = 0;
    m_err = 1'b0; m_fs = 1'b0; m_hs = 1'b0; m_vs = 1'b0;
    m_hr_last = 1'b0; m_vr_last = 1'b0;
  endtask

  // Reference: x from time since last hsync rise, periods from timestamps and
  // line counts, lock as a run length of good periods.
  task automatic model_tick(input bit h, input bit v, input bit c);
    bit hr, vr, wrap, good, set;
    int px, py;
    hr = h && !m_hs;
    vr = v && !m_vs;
    m_hs = h;
    m_vs = v;
    m_t++;
    px = m_x;
    py = m_y;
    wrap = (m_x == HT - 1) && !hr;
    set = 1'b0;
    if (hr) begin
      good = m_hhave && (m_t - m_base == HT);
      if (good) m_hlk = (m_hlk < LK) ? m_hlk + 1 : LK;
      else begin
        if (m_hlk == LK) set = 1'b1;
        m_hlk = 0;
      end
      m_hhave = 1;
      m_base = m_t;
      m_x = HSS;
    end else begin
      if (m_t - m_base >= 1023) set = 1'b1;
      m_x = ((m_hhave != 0 ? HSS : 0) + m_t - m_base) % HT;
    end
    if (vr) begin
      good = m_vhave && (m_vcnt + int'(wrap) == VT);
      if (good) m_vlk = (m_vlk < LK) ? m_vlk + 1 : LK;
      else begin
        if (m_vlk == LK) set = 1'b1;
        m_vlk = 0;
      end
      m_vhave = 1;
      m_vcnt = 0;
      m_y = VSS;
    end else if (wrap) begin
      if (m_vcnt >= 1022) set = 1'b1;
      m_vcnt = (m_vcnt < 1023) ? m_vcnt + 1 : 1023;
      m_y = (m_y + 1) % VT;
    end
    if (set) m_err = 1'b1;
    else if (c) m_err = 1'b0;
    m_fs = (m_x == 0) && (m_y == 0) && !((px == 0) && (py == 0));
    m_hr_last = hr;
    m_vr_last = vr;
  endtask

  // One pixel tick, preceded by 0..1 idle clocks with p_tick low.
  task automatic dut_tick(input bit h, input bit v, input bit c);
    int gap;
    gap = $urandom_range(0, 1);
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    hs_in = h; vs_in = v; err_clr = c; p_tick = 1'b1;
    model_tick(h, v, c);
    @(posedge clk);
    #1;
    p_tick = 1'b0;
    err_clr = 1'b0;
  endtask

  task automatic src_tick(input bit kill_h, input bit c, input bit hold);
    bit h, v;
    h = !kill_h && (sx >= HSS) && (sx < HSS + HW);
    v = (sy >= VSS) && (sy < VSS + VW);
    dut_tick(h, v, c);
    ps_x = sx;
    ps_y = sy;
    if (!hold) begin
      if (sx == HT - 1) begin
        sx = 0;
        sy = (sy + 1) % VT;
      end else begin
        sx++;
      end
    end
  endtask

  task automatic apply_reset(input int n);
    reset = 1'b0;
    repeat (n) begin
      p_tick = 1'($urandom_range(0, 1));
      hs_in = 1'($urandom_range(0, 1));
      vs_in = 1'($urandom_range(0, 1));
      err_clr = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    p_tick = 1'b0; hs_in = 1'b0; vs_in = 1'b0; err_clr = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    apply_reset(3);
    checks++; if (pixel_x !== 10'd0) begin errors++; $display("FAIL rst_x got %0d want 0", pixel_x); end
    checks++; if (pixel_y !== 10'd0) begin errors++; $display("FAIL rst_y got %0d want 0", pixel_y); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL rst_locked got %0b want 0", locked); end
    checks++; if (video_on !== 1'b0) begin errors++; $display("FAIL rst_video got %0b want 0", video_on); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL rst_fs got %0b want 0", frame_start); end
    checks++; if (timing_err !== 1'b0) begin errors++; $display("FAIL rst_err got %0b want 0", timing_err); end
  endtask

  task automatic test_nominal();
    bit hgot, vgot;
    int vr_cnt, fs_cnt, zc;
    hgot = 1'b0; vgot = 1'b0; vr_cnt = 0; fs_cnt = 0; zc = 0;
    sx = 0;
    sy = $urandom_range(0, VSS - 1);
    for (int k = 0; k < 5 * HT * VT; k++) begin
      src_tick(1'b0, 1'b0, 1'b0);
      if (m_hr_last) hgot = 1'b1;
      if (m_vr_last) begin vgot = 1'b1; vr_cnt++; end
      if (hgot) begin
        checks++; if (pixel_x !== 10'(ps_x)) begin errors++; $display("FAIL nom_x t=%0d got %0d want %0d", m_t, pixel_x, ps_x); end
      end
      if (vgot) begin
        checks++; if (pixel_y !== 10'(ps_y)) begin errors++; $display("FAIL nom_y t=%0d got %0d want %0d", m_t, pixel_y, ps_y); end
        if (ps_x == 0 && ps_y == 0) zc++;
        if (frame_start === 1'b1) fs_cnt++;
      end
      if (m_vr_last && vr_cnt <= 3) begin
        checks++; if (locked !== (vr_cnt == 3)) begin errors++; $display("FAIL nom_lock_at_vrise n=%0d got %0b want %0b", vr_cnt, locked, vr_cnt == 3); end
      end
      checks++; if (locked !== exp_locked()) begin errors++; $display("FAIL nom_locked t=%0d got %0b want %0b", m_t, locked, exp_locked()); end
      checks++; if (video_on !== exp_video()) begin errors++; $display("FAIL nom_video t=%0d got %0b want %0b", m_t, video_on, exp_video()); end
      checks++; if (frame_start !== m_fs) begin errors++; $display("FAIL nom_fs t=%0d got %0b want %0b", m_t, frame_start, m_fs); end
      checks++; if (timing_err !== m_err) begin errors++; $display("FAIL nom_err t=%0d got %0b want %0b", m_t, timing_err, m_err); end
    end
    checks++; if (fs_cnt != zc || zc < 3) begin errors++; $display("FAIL nom_fs_count got %0d want %0d (>=3)", fs_cnt, zc); end
  endtask

  task automatic test_tick_gating();
    for (int k = 0; k < 8; k++) begin
      src_tick(1'b0, 1'b0, 1'b0);
      repeat (3) begin
        p_tick = 1'b0;
        hs_in = 1'($urandom_range(0, 1));
        vs_in = 1'($urandom_range(0, 1));
        err_clr = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        checks++; if (pixel_x !== 10'(m_x)) begin errors++; $display("FAIL gate_x got %0d want %0d", pixel_x, m_x); end
        checks++; if (pixel_y !== 10'(m_y)) begin errors++; $display("FAIL gate_y got %0d want %0d", pixel_y, m_y); end
        checks++; if (locked !== exp_locked()) begin errors++; $display("FAIL gate_locked got %0b want %0b", locked, exp_locked()); end
        checks++; if (timing_err !== m_err) begin errors++; $display("FAIL gate_err got %0b want %0b", timing_err, m_err); end
        checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL gate_fs got %0b want 0", frame_start); end
      end
      err_clr = 1'b0;
    end
  endtask

  task automatic test_coincident_edge();
    bit found;
    found = 1'b0;
    for (int k = 0; k < 2 * HT * VT && !found; k++) begin
      src_tick(1'b0, 1'b0, 1'b0);
      if (m_vr_last) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL coin_wait got no vsync rise want one");
    end else begin
      if (pixel_y !== 10'(VSS)) begin errors++; $display("FAIL coin_y got %0d want %0d", pixel_y, VSS); end
      checks++; if (pixel_x !== 10'd0) begin errors++; $display("FAIL coin_x got %0d want 0", pixel_x); end
      checks++; if (timing_err !== 1'b0) begin errors++; $display("FAIL coin_err got %0b want 0", timing_err); end
      checks++; if (locked !== 1'b1) begin errors++; $display("FAIL coin_locked got %0b want 1", locked); end
    end
  endtask

  // Advance to the next hsync rise, checking the model on every tick.
  task automatic run_to_hrise(input bit kill_h, output bit found);
    found = 1'b0;
    for (int k = 0; k < 3 * HT && !found; k++) begin
      src_tick(kill_h, 1'b0, 1'b0);
      if (m_hr_last) found = 1'b1;
    end
  endtask

  task automatic test_long_line();
    bit found;
    bit want [3] = '{1'b0, 1'b0, 1'b1};
    found = 1'b0;
    for (int k = 0; k < 2 * HT * VT && !found; k++) begin
      if (sx == 5 && sy == 2) found = 1'b1;
      else src_tick(1'b0, 1'b0, 1'b0);
    end
    src_tick(1'b0, 1'b0, 1'b1);
    for (int r = 0; r < 3; r++) begin
      run_to_hrise(1'b0, found);
      checks++; if (!found || locked !== want[r]) begin errors++; $display("FAIL long_locked rise=%0d got %0b want %0b", r, locked, want[r]); end
      checks++; if (timing_err !== 1'b1) begin errors++; $display("FAIL long_err rise=%0d got %0b want 1", r, timing_err); end
      checks++; if (pixel_y !== 10'(m_y)) begin errors++; $display("FAIL long_y got %0d want %0d", pixel_y, m_y); end
    end
    src_tick(1'b0, 1'b1, 1'b0);
    checks++; if (timing_err !== 1'b0) begin errors++; $display("FAIL long_clr got %0b want 0", timing_err); end
  endtask

  task automatic test_missing_hsync();
    bit found;
    found = 1'b0;
    for (int k = 0; k < 2 * HT && !found; k++) begin
      if (sx == HSS + HW) found = 1'b1;
      else src_tick(1'b0, 1'b0, 1'b0);
    end
    for (int k = 1; k <= 1100; k++) begin
      src_tick(1'b1, 1'b0, 1'b0);
      checks++; if (pixel_x !== 10'(ps_x)) begin errors++; $display("FAIL miss_x k=%0d got %0d want %0d", k, pixel_x, ps_x); end
      checks++; if (timing_err !== m_err) begin errors++; $display("FAIL miss_err_model k=%0d got %0b want %0b", k, timing_err, m_err); end
      if (k == 900) begin
        checks++; if (timing_err !== 1'b0) begin errors++; $display("FAIL miss_err_early got %0b want 0", timing_err); end
      end
    end
    checks++; if (timing_err !== 1'b1) begin errors++; $display("FAIL miss_err_sat got %0b want 1", timing_err); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL miss_locked_hold got %0b want 1", locked); end
    run_to_hrise(1'b0, found);
    checks++; if (!found || locked !== 1'b0) begin errors++; $display("FAIL miss_locked_drop got %0b want 0", locked); end
  endtask

  task automatic test_reset_midframe();
    bit found;
    int vr_cnt;
    found = 1'b0;
    for (int k = 0; k < 4 * HT * VT && !found; k++) begin
      src_tick(1'b0, 1'b0, 1'b0);
      if (locked === 1'b1 && sx == 10 && sy == 5) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL mid_prelock got no lock want lock"); end
    apply_reset(1);
    checks++; if (pixel_x !== 10'd0 || pixel_y !== 10'd0) begin errors++; $display("FAIL mid_rst_xy got %0d,%0d want 0,0", pixel_x, pixel_y); end
    checks++; if (locked !== 1'b0 || video_on !== 1'b0) begin errors++; $display("FAIL mid_rst_lock got %0b%0b want 00", locked, video_on); end
    checks++; if (frame_start !== 1'b0 || timing_err !== 1'b0) begin errors++; $display("FAIL mid_rst_flags got %0b%0b want 00", frame_start, timing_err); end
    vr_cnt = 0;
    for (int k = 0; k < 4 * HT * VT && vr_cnt < 4; k++) begin
      src_tick(1'b0, 1'b0, 1'b0);
      if (m_vr_last) begin
        vr_cnt++;
        checks++; if (locked !== (vr_cnt >= 3)) begin errors++; $display("FAIL mid_relock n=%0d got %0b want %0b", vr_cnt, locked, vr_cnt >= 3); end
      end
      checks++; if (locked !== exp_locked()) begin errors++; $display("FAIL mid_locked t=%0d got %0b want %0b", m_t, locked, exp_locked()); end
      checks++; if (video_on !== exp_video()) begin errors++; $display("FAIL mid_video t=%0d got %0b want %0b", m_t, video_on, exp_video()); end
    end
    checks++; if (vr_cnt < 4) begin errors++; $display("FAIL mid_vrise_count got %0d want 4", vr_cnt); end
  endtask

  initial begin
    reset = 1'b1; p_tick = 1'b0; hs_in = 1'b0; vs_in = 1'b0; err_clr = 1'b0;
    model_reset();
    sx = 0; sy = 0; ps_x = 0; ps_y = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_nominal();
    test_tick_gating();
    test_coincident_edge();
    test_long_line();
    test_missing_hsync();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_sync_rx.md
Name: vga_sync_rx

Overview:
- Receive-side counterpart of the VGA 640x480 sync generator: consumes hsync/vsync plus the pixel-enable tick and recovers pixel_x/pixel_y, video_on and a lock indication.
- Sits in front of frame-capture and on-screen checker logic, and in loopback benches against the generator.
- Measures line and frame periods, declares lock after consecutive matches, and flags timing violations.

Parameters:
- HD, 640, horizontal display pixels
- H_SYNC_START, 656, pixel_x value at hsync rising edge
- H_TOTAL, 800, ticks per line
- VD, 480, vertical display lines
- V_SYNC_START, 513, pixel_y value at vsync rising edge
- V_TOTAL, 525, lines per frame
- LOCK_CNT, 2, consecutive matching periods needed for lock (range 1..7)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- p_tick  in  1  pixel enable; all state below advances only on clk edges with p_tick=1
- hsync_in  in  1  horizontal sync, active-high during retrace
- vsync_in  in  1  vertical sync, active-high during retrace
- pixel_x  out  10  recovered column
- pixel_y  out  10  recovered row
- video_on  out  1  locked && pixel_x<HD && pixel_y<VD
- locked  out  1  h_locked && v_locked
- frame_start  out  1  one-clk pulse when (pixel_x,pixel_y) becomes (0,0)
- timing_err  out  1  sticky; set on any period mismatch
- err_clr  in  1  clears timing_err; set wins if both occur on the same tick

Behaviour:
- Reset, sampled on the clk edge with reset=0: all outputs 0, all internal counters and registers 0. This applies from any state, including mid-line.
- Edge detect: hs_d/vs_d sample hsync_in/vsync_in on each tick. h_rise = p_tick & hsync_in & ~hs_d; v_rise = p_tick & vsync_in & ~vs_d. Detection is combinational, with no extra latency.
- pixel_x, on each tick, in priority order:
  - h_rise: load H_SYNC_START.
  - x==H_TOTAL-1: wrap to 0.
  - otherwise: x+1.
  - With no syncs present, x free-runs modulo H_TOTAL.
- Line wrap: asserted on a tick where x==H_TOTAL-1 and no h_rise.
- pixel_y, on each tick, in priority order:
  - v_rise: load V_SYNC_START. The load wins even when a line wrap occurs on the same tick.
  - line wrap and y==V_TOTAL-1: 0.
  - line wrap: y+1.
  - otherwise: hold.
- h_per (10 b, saturates at 1023):
  - Cleared on h_rise; +1 on every other tick.
  - At h_rise, match iff h_per==H_TOTAL-1. The comparison uses the pre-clear value.
  - The first h_rise after reset is never a match.
- v_per (10 b, saturating):
  - Cleared on v_rise; +1 on each line wrap.
  - At v_rise, match iff v_per+wrap_this_tick==V_TOTAL.
  - The first v_rise after reset is never a match.
- Lock counters (3 b, saturate at LOCK_CNT):
  - h_lk: +1 on h match, cleared on h mismatch. h_locked = (h_lk==LOCK_CNT).
  - v_lk: the same using v_rise.
  - h and v lock are independent.
- timing_err: set on any mismatch while the respective lock is held, or when h_per/v_per saturates.
- frame_start: registered. It is 1 for exactly one clk following a tick on which (x,y) transitioned to (0,0) from a different value. It is 0 otherwise.
- video_on and locked are combinational from registers; no glitch on p_tick=0 cycles.
- No outputs change on clk edges with p_tick=0, except frame_start falling.

Test Plan:
- Reset: hold reset=0 for 3 clks with random syncs -> pixel_x=pixel_y=0; locked, video_on, frame_start, timing_err all 0.
- Nominal loopback: source with hsync high for x=656..751 and vsync high for y=513..514 (800x525 ticks).
  - pixel_x==source x on every tick after the first hsync rise.
  - pixel_y==source y after the first vsync rise.
  - locked rises at the 3rd vsync rise.
  - video_on matches source x<640&&y<480.
  - frame_start pulses once per 420000 ticks.
- Long line: one line of 801 ticks while locked.
  - At the next hsync rise: locked->0 and timing_err->1.
  - locked returns at the 2nd subsequent good hsync rise, provided v_lk still holds.
  - err_clr then clears timing_err.
- Coincident edge: vsync rise on the same tick as x==799.
  - y loads 513, not y+1.
  - v match evaluates as 525 -> no error.
- Missing hsync: stop hsync after lock.
  - x free-runs and wraps 799->0.
  - h_per saturates at 1023 -> timing_err=1.
  - The next hsync rise is a mismatch -> locked=0.
- Reset mid-frame: assert reset at x=300,y=200 while locked.
  - All outputs go to 0 the next edge.
  - Lock is reacquired per the nominal case, counted from the first post-reset edges.
